nand_serial_logic: RTL and testbench



---
 rtl/nand_serial_logic_pkg.sv | 47 ++++
 rtl/nand_serial_logic_if.sv | 28 ++
 rtl/nand_serial_logic_nand_1b.sv | 12 +
 rtl/nand_serial_logic.sv | 144 ++++++++++++++
 tb/tb_nand_serial_logic.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/nand_serial_logic_pkg.sv
// rtl/nand_serial_logic_pkg.sv - shared op codes, step counts and FSM states
// Purpose: constants shared by the bit-serial NAND logic unit.
//   Op encodings, per-op NAND step counts, FSM state encoding and two
//   small helpers (op legality and index of the final step).
// Ports: none (package).
package nsl_pkg;

   localparam logic [2:0] OP_NAND = 3'd0;
   localparam logic [2:0] OP_AND  = 3'd1;
   localparam logic [2:0] OP_OR   = 3'd2;
   localparam logic [2:0] OP_XOR  = 3'd3;
   localparam logic [2:0] OP_NOT  = 3'd4;
   localparam logic [2:0] OP_NOR  = 3'd5;

   localparam int K_NAND = 1;
   localparam int K_AND  = 2;
   localparam int K_OR   = 3;
   localparam int K_XOR  = 4;
   localparam int K_NOT  = 1;
   localparam int K_NOR  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic op_legal(input logic [2:0] op);
      return (op <= OP_NOR);
   endfunction

   // Index of the last step (k-1); k=4 does not fit the 2-bit step counter.
   function automatic logic [1:0] last_step_of(input logic [2:0] op);
      logic [1:0] s;
      case (op)
         OP_NAND: s = 2'(K_NAND - 1);
         OP_AND:  s = 2'(K_AND - 1);
         OP_OR:   s = 2'(K_OR - 1);
         OP_XOR:  s = 2'(K_XOR - 1);
         OP_NOT:  s = 2'(K_NOT - 1);
         OP_NOR:  s = 2'(K_NOR - 1);
         default: s = 2'd0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/nand_serial_logic_if.sv
// rtl/nand_serial_logic_if.sv - request/response bundle of the serial logic unit
// Purpose: groups the request (start/op/a/b) and response
//   (busy/done/err/result) signals.
// Ports:
//   master : drives start, op, a, b; observes busy, done, err, result
//   slave  : the logic unit side
interface nand_serial_logic_if #(
   parameter int W = 8
);
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic         err;
   logic [W-1:0] result;

   modport master (
      output start, op, a, b,
      input  busy, done, err, result
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, err, result
   );
endinterface

// File: rtl/nand_serial_logic_nand_1b.sv
// rtl/nand_serial_logic_nand_1b.sv - single 1-bit NAND primitive
// Purpose: the only logic gate the serial unit evaluates through.
// Ports:
//   x, y : inputs
//   z    : ~(x & y)
module nand_1b (
   input  logic x,
   input  logic y,
   output logic z
);
   assign z = ~(x & y);
endmodule

// File: rtl/nand_serial_logic.sv
// rtl/nand_serial_logic.sv - bit-serial logic unit built on one NAND gate
// Purpose: latches operands on accept and walks each bit (LSB first)
//   through a per-op schedule of NAND steps, one step per clock.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of nand_serial_logic_if (start/op/a/b in,
//         busy/done/err/result out)
module nand_serial_logic
   import nsl_pkg::*;
#(
   parameter int W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   nand_serial_logic_if.slave   bus
);
   localparam int BW = $clog2(W);

   state_t          state, state_nx;
   logic [2:0]      op_q;
   logic [W-1:0]    a_q, b_q;
   logic [W-1:0]    result_q;
   logic            err_q;
   logic            t, u, v;
   logic [BW-1:0]   bit_idx;
   logic [1:0]      step;
   logic            x, y, z;
   logic            a_bit, b_bit;
   logic            last_step, last_bit;

   assign a_bit     = a_q[bit_idx];
   assign b_bit     = b_q[bit_idx];
   assign last_step = (step == last_step_of(op_q));
   assign last_bit  = (bit_idx == BW'(W - 1));

   nand_1b u_nand (
      .x (x),
      .y (y),
      .z (z)
   );

   // Step mux: NOR runs the OR schedule into v, then inverts v.
   always_comb begin
      x = 1'b0;
      y = 1'b0;
      case (op_q)
         OP_NAND: begin x = a_bit; y = b_bit; end
         OP_NOT:  begin x = a_bit; y = a_bit; end
         OP_AND: begin
            if (step == 2'd0) begin x = a_bit; y = b_bit; end
            else              begin x = t;     y = t;     end
         end
         OP_OR, OP_NOR: begin
            case (step)
               2'd0:    begin x = a_bit; y = a_bit; end
               2'd1:    begin x = b_bit; y = b_bit; end
               2'd2:    begin x = t;     y = u;     end
               default: begin x = v;     y = v;     end
            endcase
         end
         OP_XOR: begin
            case (step)
               2'd0:    begin x = a_bit; y = b_bit; end
               2'd1:    begin x = a_bit; y = t;     end
               2'd2:    begin x = b_bit; y = t;     end
               default: begin x = u;     y = v;     end
            endcase
         end
         default: begin x = 1'b0; y = 1'b0; end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (bus.start) state_nx = op_legal(bus.op) ? ST_RUN : ST_DONE;
         ST_RUN:  if (last_step && last_bit) state_nx = ST_DONE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      bus.busy   = (state == ST_RUN);
      bus.done   = (state == ST_DONE);
      bus.err    = err_q;
      bus.result = result_q;
   end

   // Datapath: non-final step s writes scratch t/u/v in order; final step
   // writes the result bit and advances to the next bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         t        <= 1'b0;
         u        <= 1'b0;
         v        <= 1'b0;
         bit_idx  <= '0;
         step     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  op_q     <= bus.op;
                  a_q      <= bus.a;
                  b_q      <= bus.b;
                  result_q <= '0;
                  err_q    <= ~op_legal(bus.op);
                  bit_idx  <= '0;
                  step     <= '0;
               end
            end
            ST_RUN: begin
               if (last_step) begin
                  result_q[bit_idx] <= z;
                  step              <= '0;
                  if (!last_bit) bit_idx <= bit_idx + 1'b1;
               end else begin
                  case (step)
                     2'd0:    t <= z;
                     2'd1:    u <= z;
                     default: v <= z;
                  endcase
                  step <= step + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nand_serial_logic.sv
// tb/tb_nand_serial_logic.sv - scoreboard bench for nand_serial_logic
module tb_nand_serial_logic;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   nand_serial_logic_if #(.W(W)) bus ();

   nand_serial_logic #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [W-1:0] res;
      logic         err;
      int           lat;
   } exp_t;

   exp_t sb[$];
   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      e.err = 1'b0;
      case (op)
         3'd0: begin e.res = ~(a & b); e.lat = W * 1; end
         3'd1: begin e.res = a & b;    e.lat = W * 2; end
         3'd2: begin e.res = a | b;    e.lat = W * 3; end
         3'd3: begin e.res = a ^ b;    e.lat = W * 4; end
         3'd4: begin e.res = ~a;       e.lat = W * 1; end
         3'd5: begin e.res = ~(a | b); e.lat = W * 4; end
         default: begin e.res = '0; e.err = 1'b1; e.lat = 0; end
      endcase
      return e;
   endfunction

   // Drives one request, then waits for done. lat counts edges after the
   // accept edge E0 until done is visible (illegal op: 0).
   task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit perturb);
      exp_t e;
      int cyc, busy_cyc;
      bit seen;
      sb.push_back(model(op, a, b));
      @(negedge clk);
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      cyc = 0; busy_cyc = 0; seen = 1'b0;
      while (cyc <= 200) begin
         if (bus.done) begin seen = 1'b1; break; end
         if (bus.busy) busy_cyc++;
         if (perturb) begin
            bus.start = ~bus.start;
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            bus.op    = 3'($urandom_range(0, 7));
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus.start = 1'b0;
      e = sb.pop_front();
      if (!seen) begin
         check({tag, "_timeout"}, 32'd0, 32'd1);
         return;
      end
      check({tag, "_result"},  32'(bus.result), 32'(e.res));
      check({tag, "_err"},     32'(bus.err),    32'(e.err));
      check({tag, "_latency"}, 32'(cyc),        32'(e.lat));
      check({tag, "_busy"},    32'(busy_cyc),   32'(e.lat));
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, 32'(bus.done),   32'd0);
      check({tag, "_hold"},       32'(bus.result), 32'(e.res));
   endtask

   // Starts an op, lets n steps execute, then holds rst for 2 cycles.
   task automatic abort_run(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input int n);
      @(negedge clk);
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (n) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check({tag, "_rst_busy"},   32'(bus.busy),   32'd0);
      check({tag, "_rst_done"},   32'(bus.done),   32'd0);
      check({tag, "_rst_err"},    32'(bus.err),    32'd0);
      check({tag, "_rst_result"}, 32'(bus.result), 32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy",   32'(bus.busy),   32'd0);
      check("reset_done",   32'(bus.done),   32'd0);
      check("reset_err",    32'(bus.err),    32'd0);
      check("reset_result", 32'(bus.result), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("nand_f0_cc", 3'd0, 8'hF0, 8'hCC, 1'b0);
      run_op("xor_a5_0f",  3'd3, 8'hA5, 8'h0F, 1'b0);
      run_op("or_12_40",   3'd2, 8'h12, 8'h40, 1'b0);
      run_op("and_perturb", 3'd1, 8'hFF, 8'h3C, 1'b1);

      abort_run("mid_and", 3'd1, 8'h55, 8'hAA, 5);
      run_op("after_rst1", 3'd0, 8'h0F, 8'h33, 1'b0);
      abort_run("mid_xor", 3'd3, 8'hA5, 8'h0F, 10);
      run_op("after_rst2", 3'd1, 8'hFF, 8'h3C, 1'b0);

      run_op("illegal_6", 3'd6, 8'h12, 8'h34, 1'b0);
      run_op("not_0f",    3'd4, 8'h0F, 8'h00, 1'b0);
      run_op("illegal_7", 3'd7, 8'hFF, 8'hFF, 1'b0);
      run_op("nor_00_00", 3'd5, 8'h00, 8'h00, 1'b0);
      run_op("nor_81_18", 3'd5, 8'h81, 8'h18, 1'b0);
      run_op("xor_ff_ff", 3'd3, 8'hFF, 8'hFF, 1'b0);

      for (int i = 0; i < 12; i++) begin
         run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 7)),
                W'($urandom), W'($urandom), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
